// File: rtl/vga_axil_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite slave (VGA CSR block) among NUM_M masters.
// Write and read channels each run their own FSM with one outstanding transaction.
module vga_axil_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  // Every channel is valid/ready: a beat transfers on the rising edge where both are high;
  // an asserted valid is held with its payload stable until that edge.
  input  logic [NUM_M-1:0]           s_awvalid,
  input  logic [NUM_M*ADDR_W-1:0]    s_awaddr,
  output logic [NUM_M-1:0]           s_awready,
  input  logic [NUM_M-1:0]           s_wvalid,
  input  logic [NUM_M*DATA_W-1:0]    s_wdata,
  input  logic [NUM_M*DATA_W/8-1:0]  s_wstrb,
  output logic [NUM_M-1:0]           s_wready,
  output logic [NUM_M-1:0]           s_bvalid,
  output logic [1:0]                 s_bresp,
  input  logic [NUM_M-1:0]           s_bready,
  input  logic [NUM_M-1:0]           s_arvalid,
  input  logic [NUM_M*ADDR_W-1:0]    s_araddr,
  output logic [NUM_M-1:0]           s_arready,
  output logic [NUM_M-1:0]           s_rvalid,
  output logic [DATA_W-1:0]          s_rdata,
  output logic [1:0]                 s_rresp,
  input  logic [NUM_M-1:0]           s_rready,
  output logic                       m_awvalid,
  output logic [ADDR_W-1:0]          m_awaddr,
  input  logic                       m_awready,
  output logic                       m_wvalid,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  input  logic                       m_wready,
  input  logic                       m_bvalid,
  input  logic [1:0]                 m_bresp,
  output logic                       m_bready,
  output logic                       m_arvalid,
  output logic [ADDR_W-1:0]          m_araddr,
  input  logic                       m_arready,
  input  logic                       m_rvalid,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic [1:0]                 m_rresp,
  output logic                       m_rready,
  // FSM state for observation: 0 idle, 1 address phase, 2 response/data phase
  output logic [1:0]                 wr_state,
  output logic [1:0]                 rd_state
);

  localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rstate_t;

  // First requester found searching cyclically from the master after the last winner.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_M) idx = idx - NUM_M;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  wstate_t          w_state, w_next;
  logic [IDX_W-1:0] wgnt, last_w;
  logic             aw_done, w_done;
  logic [NUM_M-1:0] w_req;
  logic             aw_hs, w_hs, b_hs;

  assign w_req    = s_awvalid & s_wvalid;
  assign aw_hs    = m_awvalid & m_awready;
  assign w_hs     = m_wvalid & m_wready;
  assign b_hs     = m_bvalid & m_bready;
  assign wr_state = w_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      wgnt    <= '0;
      last_w  <= IDX_W'(NUM_M - 1);
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      case (w_state)
        W_IDLE: if (|w_req) begin
          wgnt    <= rr_pick(w_req, last_w);
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        W_ADDR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        W_RESP: if (b_hs) begin
          last_w  <= wgnt;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (|w_req) w_next = W_ADDR;
      W_ADDR:  if ((aw_done | aw_hs) && (w_done | w_hs)) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // AW and W are independent beats; each drops once it has transferred.
  always_comb begin
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_bready  = 1'b0;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bresp   = '0;
    case (w_state)
      W_ADDR: begin
        m_awvalid       = !aw_done;
        m_wvalid        = !w_done;
        m_awaddr        = s_awaddr[int'(wgnt)*ADDR_W +: ADDR_W];
        m_wdata         = s_wdata[int'(wgnt)*DATA_W +: DATA_W];
        m_wstrb         = s_wstrb[int'(wgnt)*STRB_W +: STRB_W];
        s_awready[wgnt] = m_awready & !aw_done;
        s_wready[wgnt]  = m_wready & !w_done;
      end
      W_RESP: begin
        m_bready       = s_bready[wgnt];
        s_bvalid[wgnt] = m_bvalid;
        s_bresp        = m_bresp;
      end
      default: ;
    endcase
  end

  rstate_t          r_state, r_next;
  logic [IDX_W-1:0] rgnt, last_r;
  logic             ar_hs, r_hs;

  assign ar_hs    = m_arvalid & m_arready;
  assign r_hs     = m_rvalid & m_rready;
  assign rd_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      rgnt    <= '0;
      last_r  <= IDX_W'(NUM_M - 1);
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && |s_arvalid) rgnt <= rr_pick(s_arvalid, last_r);
      if (r_state == R_DATA && r_hs)       last_r <= rgnt;
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (|s_arvalid) r_next = R_ADDR;
      R_ADDR:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    m_arvalid = 1'b0;
    m_araddr  = '0;
    m_rready  = 1'b0;
    s_arready = '0;
    s_rvalid  = '0;
    s_rdata   = '0;
    s_rresp   = '0;
    case (r_state)
      R_ADDR: begin
        m_arvalid       = 1'b1;
        m_araddr        = s_araddr[int'(rgnt)*ADDR_W +: ADDR_W];
        s_arready[rgnt] = m_arready;
      end
      R_DATA: begin
        m_rready       = s_rready[rgnt];
        s_rvalid[rgnt] = m_rvalid;
        s_rdata        = m_rdata;
        s_rresp        = m_rresp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vga_axil_arbiter.sv
// Bench for vga_axil_arbiter: task-driven masters and slave, grant order predicted
// from a round-robin reference model kept per direction.
module tb_vga_axil_arbiter;

  localparam int NUM_M  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_M-1:0]          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [NUM_M-1:0]          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NUM_M*ADDR_W-1:0]   s_awaddr, s_araddr;
  logic [NUM_M*DATA_W-1:0]   s_wdata;
  logic [NUM_M*STRB_W-1:0]   s_wstrb;
  logic [1:0]                s_bresp, s_rresp, m_bresp, m_rresp, wr_state, rd_state;
  logic [DATA_W-1:0]         s_rdata, m_wdata, m_rdata;
  logic [ADDR_W-1:0]         m_awaddr, m_araddr;
  logic [STRB_W-1:0]         m_wstrb;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;

  vga_axil_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .wr_state(wr_state), .rd_state(rd_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: last winner per direction and each master's pending payload.
  int                exp_last_w, exp_last_r;
  logic [ADDR_W-1:0] cur_waddr[NUM_M];
  logic [DATA_W-1:0] cur_wdata[NUM_M];
  logic [STRB_W-1:0] cur_wstrb[NUM_M];
  logic [ADDR_W-1:0] cur_raddr[NUM_M];

  function automatic int rr_model(input logic [NUM_M-1:0] mask, input int last);
    for (int k = 1; k <= NUM_M; k++)
      if (mask[(last + k) % NUM_M]) return (last + k) % NUM_M;
    return -1;
  endfunction

  function automatic logic [NUM_M-1:0] oh(input int i);
    logic [NUM_M-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
  endtask

  task automatic new_payload(input int i);
    cur_waddr[i] = $urandom;
    cur_wdata[i] = $urandom;
    cur_wstrb[i] = STRB_W'($urandom_range(1, (1 << STRB_W) - 1));
  endtask

  task automatic write_txn(input logic [NUM_M-1:0] mask, input int aw_dly, input int w_dly,
                           input logic [1:0] resp, input int b_stall, output int obs);
    int g, cyc, aw_hs, w_hs;
    bit aw_seen, w_seen, aw_now, w_now;
    obs = -1;
    g = rr_model(mask, exp_last_w);
    for (int i = 0; i < NUM_M; i++) begin
      s_awvalid[i] = mask[i];
      s_wvalid[i]  = mask[i];
      s_awaddr[i*ADDR_W +: ADDR_W] = cur_waddr[i];
      s_wdata[i*DATA_W +: DATA_W]  = cur_wdata[i];
      s_wstrb[i*STRB_W +: STRB_W]  = cur_wstrb[i];
    end
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; s_bready = '0;
    step();
    cyc = 0;
    while (!m_awvalid && cyc < 10) begin step(); cyc++; end
    n_checks++; if (cyc != 0) begin n_fail++; $display("FAIL aw_latency: got %0d extra cycles, want 0", cyc); end
    if (!m_awvalid) begin
      $display("FAIL aw_timeout: m_awvalid never asserted");
      n_fail++;
      s_awvalid = '0; s_wvalid = '0;
      return;
    end
    n_checks++; if (m_awaddr !== cur_waddr[g]) begin n_fail++; $display("FAIL awaddr: got %h want %h (master %0d)", m_awaddr, cur_waddr[g], g); end
    n_checks++; if (m_wdata !== cur_wdata[g] || m_wstrb !== cur_wstrb[g]) begin n_fail++; $display("FAIL wdata: got %h/%h want %h/%h", m_wdata, m_wstrb, cur_wdata[g], cur_wstrb[g]); end
    aw_seen = 0; w_seen = 0; aw_hs = 0; w_hs = 0; cyc = 0;
    while (!(aw_seen && w_seen) && cyc < 20) begin
      m_awready = (cyc >= aw_dly);
      m_wready  = (cyc >= w_dly);
      #1;
      n_checks++; if (m_awvalid !== !aw_seen || m_wvalid !== !w_seen) begin n_fail++; $display("FAIL addr_valids: got aw=%b w=%b want aw=%b w=%b", m_awvalid, m_wvalid, !aw_seen, !w_seen); end
      n_checks++; if (s_awready !== ((m_awready && !aw_seen) ? oh(g) : '0) || s_wready !== ((m_wready && !w_seen) ? oh(g) : '0)) begin n_fail++; $display("FAIL s_readies: got aw=%b w=%b cycle %0d", s_awready, s_wready, cyc); end
      aw_now = m_awvalid && m_awready;
      w_now  = m_wvalid && m_wready;
      if (aw_now) aw_hs++;
      if (w_now)  w_hs++;
      step();
      cyc++;
      if (aw_now) begin aw_seen = 1; s_awvalid[g] = 1'b0; end
      if (w_now)  begin w_seen = 1;  s_wvalid[g] = 1'b0; end
    end
    m_awready = 1'b0; m_wready = 1'b0;
    n_checks++; if (aw_hs != 1 || w_hs != 1) begin n_fail++; $display("FAIL hs_count: got aw=%0d w=%0d want 1/1", aw_hs, w_hs); end
    m_bvalid = 1'b1; m_bresp = resp;
    for (int s = 0; s < b_stall; s++) begin
      s_bready = '0;
      #1;
      n_checks++; if (m_bready !== 1'b0 || s_bvalid !== oh(g)) begin n_fail++; $display("FAIL b_stall: got bready=%b bvalid=%b", m_bready, s_bvalid); end
      n_checks++; if (s_awready !== '0 || m_awvalid !== 1'b0 || wr_state !== 2'd2) begin n_fail++; $display("FAIL b_stall_hold: got awready=%b awvalid=%b state=%0d", s_awready, m_awvalid, wr_state); end
      step();
    end
    s_bready = oh(g);
    #1;
    for (int i = 0; i < NUM_M; i++) if (s_bvalid[i]) obs = i;
    n_checks++; if (m_bready !== 1'b1 || s_bvalid !== oh(g) || s_bresp !== resp) begin n_fail++; $display("FAIL bresp: got bready=%b bvalid=%b bresp=%0d want bvalid=%b bresp=%0d", m_bready, s_bvalid, s_bresp, oh(g), resp); end
    step();
    m_bvalid = 1'b0; s_bready = '0;
    n_checks++; if (wr_state !== 2'd0) begin n_fail++; $display("FAIL w_idle: got state %0d want 0", wr_state); end
    exp_last_w = g;
    new_payload(g);
  endtask

  task automatic read_txn(input logic [NUM_M-1:0] mask, input int ar_dly, input int r_dly,
                          input logic [1:0] resp);
    int g, cyc;
    bit done;
    logic [DATA_W-1:0] rd;
    g = rr_model(mask, exp_last_r);
    for (int i = 0; i < NUM_M; i++) begin
      s_arvalid[i] = mask[i];
      s_araddr[i*ADDR_W +: ADDR_W] = cur_raddr[i];
    end
    m_arready = 1'b0; m_rvalid = 1'b0; s_rready = '0;
    step();
    cyc = 0;
    while (!m_arvalid && cyc < 10) begin step(); cyc++; end
    n_checks++; if (cyc != 0 || !m_arvalid) begin n_fail++; $display("FAIL ar_latency: got %0d extra cycles, arvalid=%b", cyc, m_arvalid); end
    if (!m_arvalid) begin s_arvalid = '0; return; end
    n_checks++; if (m_araddr !== cur_raddr[g]) begin n_fail++; $display("FAIL araddr: got %h want %h (master %0d)", m_araddr, cur_raddr[g], g); end
    done = 0; cyc = 0;
    while (!done && cyc < 20) begin
      m_arready = (cyc >= ar_dly);
      #1;
      n_checks++; if (m_arvalid !== 1'b1 || s_arready !== (m_arready ? oh(g) : '0)) begin n_fail++; $display("FAIL arready: got arvalid=%b arready=%b cycle %0d", m_arvalid, s_arready, cyc); end
      done = m_arready;
      step();
      cyc++;
    end
    s_arvalid[g] = 1'b0; m_arready = 1'b0;
    n_checks++; if (m_arvalid !== 1'b0 || rd_state !== 2'd2) begin n_fail++; $display("FAIL r_phase: got arvalid=%b state=%0d", m_arvalid, rd_state); end
    rd = $urandom;
    s_rready = oh(g);
    for (int s = 0; s < r_dly; s++) begin
      #1;
      n_checks++; if (s_rvalid !== '0 || m_rready !== 1'b1) begin n_fail++; $display("FAIL r_wait: got rvalid=%b rready=%b", s_rvalid, m_rready); end
      step();
    end
    m_rvalid = 1'b1; m_rdata = rd; m_rresp = resp;
    #1;
    n_checks++; if (s_rvalid !== oh(g) || s_rdata !== rd || s_rresp !== resp) begin n_fail++; $display("FAIL rdata: got rvalid=%b data=%h resp=%0d want %b %h %0d", s_rvalid, s_rdata, s_rresp, oh(g), rd, resp); end
    step();
    m_rvalid = 1'b0; s_rready = '0;
    n_checks++; if (rd_state !== 2'd0) begin n_fail++; $display("FAIL r_idle: got state %0d want 0", rd_state); end
    exp_last_r = g;
    cur_raddr[g] = $urandom;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    s_awvalid = '1; s_wvalid = '1; s_arvalid = '1; s_bready = '1; s_rready = '1;
    m_bvalid = 1'b1; m_rvalid = 1'b1; m_rdata = $urandom; m_bresp = 2'b10; m_rresp = 2'b11;
    repeat (3) step();
    n_checks++; if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0) begin n_fail++; $display("FAIL reset_m: got %b want 00000", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}); end
    n_checks++; if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid} !== '0) begin n_fail++; $display("FAIL reset_s: got %b", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid}); end
    n_checks++; if (s_rdata !== '0 || s_rresp !== 2'b0 || s_bresp !== 2'b0 || wr_state !== 2'd0 || rd_state !== 2'd0) begin n_fail++; $display("FAIL reset_data: got rdata=%h rresp=%0d bresp=%0d states=%0d/%0d", s_rdata, s_rresp, s_bresp, wr_state, rd_state); end
    clear_inputs();
    rst = 1'b0;
    exp_last_w = NUM_M - 1;
    exp_last_r = NUM_M - 1;
    step();
  endtask

  task automatic test_single_write();
    int obs;
    cur_waddr[0] = 32'h3; cur_wdata[0] = 32'h4; cur_wstrb[0] = 4'hf;
    write_txn(2'b01, 0, 0, 2'b00, 0, obs);
  endtask

  task automatic test_round_robin();
    int obs;
    int cnt[NUM_M];
    for (int i = 0; i < NUM_M; i++) cnt[i] = 0;
    for (int t = 0; t < 8; t++) begin
      write_txn(2'b11, $urandom_range(0, 2), $urandom_range(0, 2), 2'b00, 0, obs);
      if (obs >= 0) cnt[obs]++;
    end
    n_checks++; if (cnt[0] != 4 || cnt[1] != 4) begin n_fail++; $display("FAIL fairness: got %0d/%0d grants want 4/4", cnt[0], cnt[1]); end
  endtask

  task automatic test_aw_w_order();
    int obs;
    write_txn(2'b01, 0, 2, 2'b00, 0, obs);
    write_txn(2'b01, 2, 0, 2'b00, 0, obs);
    write_txn(2'b10, 1, 1, 2'b00, 0, obs);
  endtask

  task automatic test_concurrent();
    int obs;
    cur_raddr[1] = 32'h8;
    fork
      write_txn(2'b01, 1, 0, 2'b00, 1, obs);
      read_txn(2'b10, 1, 2, 2'b10);
    join
  endtask

  task automatic test_bready_stall();
    int obs;
    write_txn(2'b11, 0, 0, 2'b00, 5, obs);
    write_txn(2'b11, 0, 0, 2'b11, 0, obs);
  endtask

  task automatic test_random();
    int obs;
    for (int t = 0; t < 12; t++) begin
      fork
        write_txn(NUM_M'($urandom_range(1, (1 << NUM_M) - 1)), $urandom_range(0, 3),
                  $urandom_range(0, 3), 2'($urandom_range(0, 3)), $urandom_range(0, 3), obs);
        read_txn(NUM_M'($urandom_range(1, (1 << NUM_M) - 1)), $urandom_range(0, 3),
                 $urandom_range(0, 3), 2'($urandom_range(0, 3)));
      join
    end
  endtask

  task automatic test_reset_mid();
    int obs;
    write_txn(2'b01, 0, 0, 2'b00, 0, obs);
    s_awvalid = 2'b10; s_wvalid = 2'b10;
    s_awaddr[ADDR_W +: ADDR_W] = cur_waddr[1];
    s_wdata[DATA_W +: DATA_W] = cur_wdata[1];
    step();
    n_checks++; if (m_awvalid !== 1'b1 || wr_state !== 2'd1) begin n_fail++; $display("FAIL mid_grant: got awvalid=%b state=%0d", m_awvalid, wr_state); end
    rst = 1'b1;
    step();
    n_checks++; if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || s_awready !== '0 || wr_state !== 2'd0) begin n_fail++; $display("FAIL mid_reset: got awvalid=%b wvalid=%b awready=%b state=%0d", m_awvalid, m_wvalid, s_awready, wr_state); end
    rst = 1'b0;
    clear_inputs();
    exp_last_w = NUM_M - 1;
    exp_last_r = NUM_M - 1;
    write_txn(2'b11, 0, 0, 2'b00, 0, obs);
    n_checks++; if (obs != 0) begin n_fail++; $display("FAIL post_reset_grant: got master %0d want 0", obs); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_M; i++) begin
      new_payload(i);
      cur_raddr[i] = $urandom;
    end
    test_reset();
    test_single_write();
    test_round_robin();
    test_aw_w_order();
    test_concurrent();
    test_bready_stall();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
